// File: rtl/matrix_pkg.sv
// Shared select encodings, loader state type and element offset helper for the matrix register bank.
// Pure declarations: no latency, no flow control.
package matrix_pkg;

    localparam logic [1:0] MSEL_A    = 2'd0;
    localparam logic [1:0] MSEL_B    = 2'd1;
    localparam logic [1:0] MSEL_C    = 2'd2;
    localparam logic [1:0] MSEL_NONE = 2'd3;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } ld_state_t;

    function automatic int elem_off(input int row, input int col, input int dim, input int ew);
        return (row * dim + col) * ew;
    endfunction

endpackage

// File: rtl/matrix_store.sv
// One DIM x DIM matrix of EW-bit elements with two write ports; port 0 overrides port 1 on the same element.
// Writes land on the next clock edge and appear on flat_o immediately after it; no backpressure.
module matrix_store
    import matrix_pkg::*;
#(
    parameter int DIM = 3,
    parameter int EW  = 5,
    parameter int IW  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we0_i,
    input  logic [IW-1:0]         row0_i,
    input  logic [IW-1:0]         col0_i,
    input  logic [EW-1:0]         dat0_i,
    input  logic                  we1_i,
    input  logic [IW-1:0]         row1_i,
    input  logic [IW-1:0]         col1_i,
    input  logic [EW-1:0]         dat1_i,
    output logic [DIM*DIM*EW-1:0] flat_o
);

    logic [DIM*DIM*EW-1:0] flat_q;
    logic [DIM*DIM*EW-1:0] flat_d;

    // Port 0 is applied last so it wins a same-element collision.
    always_comb begin
        flat_d = flat_q;
        if (we1_i) begin
            flat_d[elem_off(int'(row1_i), int'(col1_i), DIM, EW) +: EW] = dat1_i;
        end
        if (we0_i) begin
            flat_d[elem_off(int'(row0_i), int'(col0_i), DIM, EW) +: EW] = dat0_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flat_q <= '0;
        end else begin
            flat_q <= flat_d;
        end
    end

    assign flat_o = flat_q;

endmodule

// File: rtl/matrix_regbank.sv
// A/B/C matrix storage plus n/m/p registers, with a row-major stream loader and a random element write port.
// Writes visible 1 cycle after the edge; ld_ready depends only on loader state, random port never stalls.
module matrix_regbank
    import matrix_pkg::*;
#(
    parameter int DIM = 3,
    parameter int EW  = 5,
    parameter int DW  = 6,
    parameter int IW  = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dims_we,
    input  logic [DW-1:0]         n_in,
    input  logic [DW-1:0]         m_in,
    input  logic [DW-1:0]         p_in,
    output logic [DW-1:0]         n_out,
    output logic [DW-1:0]         m_out,
    output logic [DW-1:0]         p_out,
    input  logic                  ld_start,
    input  logic [1:0]            ld_sel,
    input  logic                  ld_abort,
    input  logic                  ld_valid,
    input  logic [EW-1:0]         ld_data,
    output logic                  ld_ready,
    output logic                  ld_done,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [1:0]            wr_sel,
    input  logic [IW-1:0]         wr_row,
    input  logic [IW-1:0]         wr_col,
    input  logic [EW-1:0]         wr_data,
    output logic [DIM*DIM*EW-1:0] a_flat,
    output logic [DIM*DIM*EW-1:0] b_flat,
    output logic [DIM*DIM*EW-1:0] c_flat
);

    ld_state_t     state_q, state_d;
    logic [IW-1:0] row_q, row_d;
    logic [IW-1:0] col_q, col_d;
    logic [1:0]    tgt_q, tgt_d;
    logic [DW-1:0] n_q, m_q, p_q;
    logic          accept;
    logic          last_elem;
    logic          wr_ok;

    assign accept    = (state_q == LD_LOAD) && ld_valid;
    assign last_elem = (row_q == IW'(DIM - 1)) && (col_q == IW'(DIM - 1));
    assign wr_ok     = wr_en && (wr_sel != MSEL_NONE)
                       && (int'(wr_row) < DIM) && (int'(wr_col) < DIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LD_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            tgt_q   <= MSEL_A;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            tgt_q   <= tgt_d;
        end
    end

    // Abort is checked after the counter update so a beat in the abort cycle is still stored.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        tgt_d   = tgt_q;
        case (state_q)
            LD_IDLE: begin
                if (ld_start && (ld_sel != MSEL_NONE)) begin
                    state_d = LD_LOAD;
                    tgt_d   = ld_sel;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            LD_LOAD: begin
                if (accept) begin
                    if (col_q == IW'(DIM - 1)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                if (ld_abort) begin
                    state_d = LD_IDLE;
                end else if (accept && last_elem) begin
                    state_d = LD_DONE;
                end
            end
            LD_DONE: state_d = LD_IDLE;
            default: state_d = LD_IDLE;
        endcase
    end

    always_comb begin
        ld_ready = (state_q == LD_LOAD);
        ld_done  = (state_q == LD_DONE);
        busy     = (state_q != LD_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q <= '0;
            m_q <= '0;
            p_q <= '0;
        end else if (dims_we) begin
            n_q <= n_in;
            m_q <= m_in;
            p_q <= p_in;
        end
    end

    assign n_out = n_q;
    assign m_out = m_q;
    assign p_out = p_q;

    matrix_store #(.DIM(DIM), .EW(EW), .IW(IW)) u_store_a (
        .clk    (clk),
        .reset  (reset),
        .we0_i  (accept && (tgt_q == MSEL_A)),
        .row0_i (row_q),
        .col0_i (col_q),
        .dat0_i (ld_data),
        .we1_i  (wr_ok && (wr_sel == MSEL_A)),
        .row1_i (wr_row),
        .col1_i (wr_col),
        .dat1_i (wr_data),
        .flat_o (a_flat)
    );

    matrix_store #(.DIM(DIM), .EW(EW), .IW(IW)) u_store_b (
        .clk    (clk),
        .reset  (reset),
        .we0_i  (accept && (tgt_q == MSEL_B)),
        .row0_i (row_q),
        .col0_i (col_q),
        .dat0_i (ld_data),
        .we1_i  (wr_ok && (wr_sel == MSEL_B)),
        .row1_i (wr_row),
        .col1_i (wr_col),
        .dat1_i (wr_data),
        .flat_o (b_flat)
    );

    matrix_store #(.DIM(DIM), .EW(EW), .IW(IW)) u_store_c (
        .clk    (clk),
        .reset  (reset),
        .we0_i  (accept && (tgt_q == MSEL_C)),
        .row0_i (row_q),
        .col0_i (col_q),
        .dat0_i (ld_data),
        .we1_i  (wr_ok && (wr_sel == MSEL_C)),
        .row1_i (wr_row),
        .col1_i (wr_col),
        .dat1_i (wr_data),
        .flat_o (c_flat)
    );

endmodule
